// File: rtl/cpu_trace_decoder_pkg.sv
// Shared definitions for the 65C02 trace decoder: prefix codes, addressing
// classes and the operand-length helpers used by the capture FSM.
package cpu_trace_pkg;

    localparam logic [2:0] PFX_NONE   = 3'd0;
    localparam logic [2:0] PFX_A24    = 3'd1;
    localparam logic [2:0] PFX_R16    = 3'd2;
    localparam logic [2:0] PFX_R24    = 3'd3;
    localparam logic [2:0] PFX_A24R16 = 3'd4;
    localparam logic [2:0] PFX_A24R24 = 3'd5;
    localparam logic [2:0] PFX_BAD    = 3'd7;

    typedef enum logic [2:0] {
        CLS_IMPL,
        CLS_REL,
        CLS_ZP,
        CLS_IMM,
        CLS_ABS
    } addrClass_e;

    // 0F is an ordinary opcode; every other xF byte is a prefix.
    function automatic logic isPrefix(input logic [7:0] b);
        return (b[3:0] == 4'hF) && (b != 8'h0F);
    endfunction

    function automatic logic [2:0] prefixCode(input logic [7:0] b);
        case (b)
            8'h1F:   return PFX_A24;
            8'h4F:   return PFX_R16;
            8'h8F:   return PFX_R24;
            8'h5F:   return PFX_A24R16;
            8'h9F:   return PFX_A24R24;
            default: return PFX_BAD;
        endcase
    endfunction

    // Column-oriented decode of the 65C02 opcode map.
    function automatic addrClass_e opClass(input logic [7:0] op);
        case (op[3:0])
            4'h0: begin
                if (op[4]) return CLS_REL;
                case (op[7:4])
                    4'h0, 4'h4, 4'h6: return CLS_IMPL;
                    4'h2:             return CLS_ABS;
                    4'h8:             return CLS_REL;
                    default:          return CLS_IMM;
                endcase
            end
            4'h1, 4'h4, 4'h5, 4'h6, 4'h7: return CLS_ZP;
            4'h2: begin
                if (op[4]) return CLS_ZP;
                return (op == 8'hA2) ? CLS_IMM : CLS_IMPL;
            end
            4'h9:             return op[4] ? CLS_ABS : CLS_IMM;
            4'hC, 4'hD, 4'hE: return CLS_ABS;
            default:          return CLS_IMPL;
        endcase
    endfunction

    function automatic logic [1:0] addrWidth(input logic [2:0] pfx);
        return (pfx == PFX_A24 || pfx == PFX_A24R16 || pfx == PFX_A24R24) ? 2'd3 : 2'd2;
    endfunction

    function automatic logic [1:0] regWidth(input logic [2:0] pfx);
        if (pfx == PFX_R16 || pfx == PFX_A24R16) return 2'd2;
        if (pfx == PFX_R24 || pfx == PFX_A24R24) return 2'd3;
        return 2'd1;
    endfunction

    function automatic logic [1:0] need(input addrClass_e cls, input logic [1:0] aw,
                                        input logic [1:0] rw);
        case (cls)
            CLS_REL, CLS_ZP: return 2'd1;
            CLS_IMM:         return rw;
            CLS_ABS:         return aw;
            default:         return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_trace_decoder_fifo.sv
// Synchronous record FIFO with a registered head so the drain port is flop-driven.
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [W-1:0]           data_i,
    input  logic                   pop_i,
    output logic                   valid_o,
    output logic [W-1:0]           data_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wrPtr_q, rdPtr_q, wrPtr_d, rdPtr_d;
    logic [PW:0]   count_q, count_d;
    logic [W-1:0]  head_q, head_d;
    logic          valid_q;
    logic          doPop, doWrite;

    always_comb begin
        full_o  = (count_q == (PW+1)'(DEPTH));
        doPop   = pop_i && valid_q;
        doWrite = push_i && (!full_o || doPop);
        rdPtr_d = doPop   ? rdPtr_q + PW'(1) : rdPtr_q;
        wrPtr_d = doWrite ? wrPtr_q + PW'(1) : wrPtr_q;
        count_d = count_q;
        if (doWrite && !doPop) count_d = count_q + (PW+1)'(1);
        if (!doWrite && doPop) count_d = count_q - (PW+1)'(1);
        // When the FIFO drains to the slot being written, the new head bypasses memory.
        head_d = (doWrite && (rdPtr_d == wrPtr_q)) ? data_i : mem[rdPtr_d];
    end

    always_ff @(posedge clk_i) begin
        if (doWrite) mem[wrPtr_q] <= data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            head_q  <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            valid_q <= (count_d != '0);
            head_q  <= (count_d != '0) ? head_d : '0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = head_q;
    assign level_o = count_q;

endmodule

// File: rtl/cpu_trace_decoder.sv
// Passive 65C02 fetch-stream monitor: builds one record per instruction and
// queues it in a trace FIFO.
module cpu_trace_decoder
    import cpu_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 24,
    parameter int CYCW  = 16,
    parameter int DROPW = 16
) (
    input  logic                   clk,
    input  logic                   RST,
    input  logic                   en,
    input  logic                   sync,
    input  logic                   RDY,
    input  logic [AW-1:0]          AB,
    input  logic [7:0]             DI,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AW-1:0]          out_pc,
    output logic [7:0]             out_opcode,
    output logic [2:0]             out_pfx,
    output logic [23:0]            out_operand,
    output logic [1:0]             out_nops,
    output logic                   out_trunc,
    output logic [CYCW-1:0]        out_cycle,
    output logic [DROPW-1:0]       dropped,
    output logic [$clog2(DEPTH):0] level
);

    localparam int RECW = AW + 8 + 3 + 24 + 2 + 1 + CYCW;

    typedef enum logic [1:0] {IDLE, PFX, OPS, PUSH} state_e;

    state_e           state_q;
    logic [AW-1:0]    pc_q;
    logic [7:0]       opcode_q;
    logic [2:0]       pfx_q;
    logic [23:0]      operand_q;
    logic [1:0]       nops_q, need_q;
    logic [CYCW-1:0]  stamp_q, cycle_q;
    logic [DROPW-1:0] dropped_q;

    logic             fetch, operandHit, pushValid, fifoFull, popValid;
    logic [2:0]       startPfx;
    logic [1:0]       newNeed;
    logic [RECW-1:0]  pushData, headData;

    always_comb begin
        fetch      = sync && RDY;
        startPfx   = (state_q == PFX) ? pfx_q : PFX_NONE;
        newNeed    = need(opClass(DI), addrWidth(startPfx), regWidth(startPfx));
        operandHit = RDY && !sync && (AB == pc_q + AW'(nops_q) + AW'(1));
        // A fetch while operands are still outstanding flushes the partial record.
        pushValid  = (state_q == PUSH) || (state_q == OPS && fetch);
        pushData   = {pc_q, opcode_q, pfx_q, operand_q, nops_q, (state_q == OPS), stamp_q};
        popValid   = out_valid && out_ready;
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            opcode_q  <= '0;
            pfx_q     <= PFX_NONE;
            operand_q <= '0;
            nops_q    <= '0;
            need_q    <= '0;
            stamp_q   <= '0;
        end else begin
            case (state_q)
                PUSH: state_q <= IDLE;
                PFX:  if (!en) state_q <= IDLE;
                OPS: begin
                    if (fetch) begin
                        state_q <= IDLE;
                    end else if (operandHit) begin
                        case (nops_q)
                            2'd0:    operand_q[7:0]   <= DI;
                            2'd1:    operand_q[15:8]  <= DI;
                            default: operand_q[23:16] <= DI;
                        endcase
                        nops_q <= nops_q + 2'd1;
                        if (nops_q + 2'd1 == need_q) state_q <= PUSH;
                    end
                end
                default: ;
            endcase
            // Any enabled fetch starts a new prefix or record, whatever the state.
            if (fetch && en) begin
                if (isPrefix(DI)) begin
                    pfx_q   <= prefixCode(DI);
                    state_q <= PFX;
                end else begin
                    pc_q      <= AB;
                    opcode_q  <= DI;
                    pfx_q     <= startPfx;
                    stamp_q   <= cycle_q;
                    operand_q <= '0;
                    nops_q    <= '0;
                    need_q    <= newNeed;
                    state_q   <= (newNeed == 2'd0) ? PUSH : OPS;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            cycle_q   <= '0;
            dropped_q <= '0;
        end else begin
            cycle_q <= cycle_q + CYCW'(1);
            if (pushValid && fifoFull && !popValid && dropped_q != '1)
                dropped_q <= dropped_q + DROPW'(1);
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     (RECW)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (RST),
        .push_i  (pushValid),
        .data_i  (pushData),
        .pop_i   (out_ready),
        .valid_o (out_valid),
        .data_o  (headData),
        .full_o  (fifoFull),
        .level_o (level)
    );

    assign {out_pc, out_opcode, out_pfx, out_operand, out_nops, out_trunc, out_cycle} = headData;
    assign dropped = dropped_q;

endmodule

// File: tb/tb_cpu_trace_decoder.sv
// Directed self-checking bench for cpu_trace_decoder with hand-computed records.
module tb_cpu_trace_decoder;

    logic        clk = 1'b0;
    logic        RST = 1'b0;
    logic        en = 1'b1;
    logic        sync = 1'b0;
    logic        RDY = 1'b0;
    logic [23:0] AB = '0;
    logic [7:0]  DI = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] out_pc;
    logic [7:0]  out_opcode;
    logic [2:0]  out_pfx;
    logic [23:0] out_operand;
    logic [1:0]  out_nops;
    logic        out_trunc;
    logic [15:0] out_cycle;
    logic [15:0] dropped;
    logic [4:0]  level;

    int checkCount = 0;
    int errorCount = 0;
    int cycNow = 0;
    int stampA;

    cpu_trace_decoder #(.DEPTH(16), .AW(24), .CYCW(16), .DROPW(16)) dut (
        .clk         (clk),
        .RST         (RST),
        .en          (en),
        .sync        (sync),
        .RDY         (RDY),
        .AB          (AB),
        .DI          (DI),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_opcode  (out_opcode),
        .out_pfx     (out_pfx),
        .out_operand (out_operand),
        .out_nops    (out_nops),
        .out_trunc   (out_trunc),
        .out_cycle   (out_cycle),
        .dropped     (dropped),
        .level       (level)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cycNow++;
    endtask

    task automatic applyStimulus(input logic s, input logic r, input logic [23:0] a,
                                 input logic [7:0] d);
        sync = s;
        RDY  = r;
        AB   = a;
        DI   = d;
        tick();
    endtask

    task automatic idleBus(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 24'h0, 8'h00);
    endtask

    task automatic doReset();
        RST = 1'b1;
        idleBus(1);
        RST = 1'b0;
        cycNow = 0;
    endtask

    task automatic popRecord(input string tag, input logic [23:0] pc, input logic [7:0] op,
                             input logic [2:0] pfx, input logic [23:0] operand,
                             input logic [1:0] nops, input logic trunc, input int cyc);
        for (int i = 0; i < 20 && !out_valid; i++) idleBus(1);
        checkOutput({tag, ".valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, ".pc"}, 32'(out_pc), 32'(pc));
        checkOutput({tag, ".opcode"}, 32'(out_opcode), 32'(op));
        checkOutput({tag, ".pfx"}, 32'(out_pfx), 32'(pfx));
        checkOutput({tag, ".operand"}, 32'(out_operand), 32'(operand));
        checkOutput({tag, ".nops"}, 32'(out_nops), 32'(nops));
        checkOutput({tag, ".trunc"}, 32'(out_trunc), 32'(trunc));
        checkOutput({tag, ".cycle"}, 32'(out_cycle), 32'(cyc[15:0]));
        out_ready = 1'b1;
        idleBus(1);
        out_ready = 1'b0;
    endtask

    initial begin
        doReset();
        checkOutput("rst.valid", 32'(out_valid), 32'd0);
        checkOutput("rst.level", 32'(level), 32'd0);
        checkOutput("rst.dropped", 32'(dropped), 32'd0);
        checkOutput("rst.pc", 32'(out_pc), 32'd0);

        // LDA #imm, with a not-ready cycle on the operand address first
        applyStimulus(1, 1, 24'h001000, 8'hA9);
        applyStimulus(0, 0, 24'h001001, 8'h99);
        applyStimulus(0, 1, 24'h001001, 8'h42);
        popRecord("ldaImm", 24'h001000, 8'hA9, 3'd0, 24'h000042, 2'd1, 1'b0, 0);

        // A24+R24 prefix on LDA abs
        applyStimulus(1, 1, 24'h002000, 8'h9F);
        stampA = cycNow;
        applyStimulus(1, 1, 24'h002001, 8'hAD);
        applyStimulus(0, 1, 24'h002002, 8'h34);
        applyStimulus(0, 1, 24'h002003, 8'h12);
        applyStimulus(0, 1, 24'h002004, 8'h05);
        popRecord("pfx5Abs", 24'h002001, 8'hAD, 3'd5, 24'h051234, 2'd3, 1'b0, stampA);

        applyStimulus(1, 1, 24'h003000, 8'h4F);
        stampA = cycNow;
        applyStimulus(1, 1, 24'h003001, 8'hA2);
        applyStimulus(0, 1, 24'h003002, 8'h34);
        applyStimulus(0, 1, 24'h003003, 8'h12);
        popRecord("r16Imm", 24'h003001, 8'hA2, 3'd2, 24'h001234, 2'd2, 1'b0, stampA);

        applyStimulus(1, 1, 24'h003100, 8'h8F);
        stampA = cycNow;
        applyStimulus(1, 1, 24'h003101, 8'hA2);
        applyStimulus(0, 1, 24'h003102, 8'h34);
        applyStimulus(0, 1, 24'h003103, 8'h12);
        applyStimulus(0, 1, 24'h003104, 8'h56);
        popRecord("r24Imm", 24'h003101, 8'hA2, 3'd3, 24'h561234, 2'd3, 1'b0, stampA);

        // JSR with interleaved stack pushes
        stampA = cycNow;
        applyStimulus(1, 1, 24'h000300, 8'h20);
        applyStimulus(0, 1, 24'h000301, 8'h00);
        applyStimulus(0, 1, 24'h0001FF, 8'h03);
        applyStimulus(0, 1, 24'h0001FE, 8'h02);
        applyStimulus(0, 1, 24'h000302, 8'h80);
        popRecord("jsr", 24'h000300, 8'h20, 3'd0, 24'h008000, 2'd2, 1'b0, stampA);

        // Truncated JSR followed immediately by NOP
        stampA = cycNow;
        applyStimulus(1, 1, 24'h000400, 8'h20);
        applyStimulus(0, 1, 24'h000401, 8'h11);
        applyStimulus(1, 1, 24'h000500, 8'hEA);
        popRecord("trunc", 24'h000400, 8'h20, 3'd0, 24'h000011, 2'd1, 1'b1, stampA);
        popRecord("afterTrunc", 24'h000500, 8'hEA, 3'd0, 24'h000000, 2'd0, 1'b0, stampA + 2);

        // Overfill: DEPTH+3 back-to-back NOPs with no drain
        stampA = cycNow;
        for (int i = 0; i < 19; i++) applyStimulus(1, 1, 24'h004000 + 24'(i), 8'hEA);
        idleBus(2);
        checkOutput("full.level", 32'(level), 32'd16);
        checkOutput("full.dropped", 32'(dropped), 32'd3);
        for (int i = 0; i < 16; i++)
            popRecord($sformatf("drain%0d", i), 24'h004000 + 24'(i), 8'hEA, 3'd0, 24'h0,
                      2'd0, 1'b0, stampA + i);
        checkOutput("drained.valid", 32'(out_valid), 32'd0);
        checkOutput("drained.level", 32'(level), 32'd0);

        // Unsupported prefix on 0F, which is an ordinary opcode
        applyStimulus(1, 1, 24'h004100, 8'h2F);
        stampA = cycNow;
        applyStimulus(1, 1, 24'h004101, 8'h0F);
        popRecord("badPfx0F", 24'h004101, 8'h0F, 3'd7, 24'h0, 2'd0, 1'b0, stampA);

        // Enable dropped while a prefix is pending discards it
        applyStimulus(1, 1, 24'h004200, 8'h1F);
        en = 1'b0;
        idleBus(1);
        en = 1'b1;
        stampA = cycNow;
        applyStimulus(1, 1, 24'h004202, 8'hAD);
        applyStimulus(0, 1, 24'h004203, 8'hCD);
        applyStimulus(0, 1, 24'h004204, 8'hAB);
        popRecord("enPfx", 24'h004202, 8'hAD, 3'd0, 24'h00ABCD, 2'd2, 1'b0, stampA);

        // Reset mid-record with five queued entries
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, 24'h005000 + 24'(i), 8'hEA);
        idleBus(2);
        checkOutput("preRst.level", 32'(level), 32'd5);
        applyStimulus(1, 1, 24'h006000, 8'hAD);
        applyStimulus(0, 1, 24'h006001, 8'h01);
        doReset();
        checkOutput("midRst.level", 32'(level), 32'd0);
        checkOutput("midRst.valid", 32'(out_valid), 32'd0);
        checkOutput("midRst.dropped", 32'(dropped), 32'd0);
        applyStimulus(1, 1, 24'h007000, 8'hA9);
        applyStimulus(0, 1, 24'h007001, 8'h55);
        popRecord("postRst", 24'h007000, 8'hA9, 3'd0, 24'h000055, 2'd1, 1'b0, 0);
        checkOutput("postRst.empty", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/cpu_trace_decoder.md
Name: cpu_trace_decoder

Overview:
- Passive bus monitor for the 24-bit 65C02-family CPU; snoops the fetch stream (SYNC, address, read data, RDY).
- Assembles one record per executed instruction: prefix mode, opcode, operand bytes, PC, cycle stamp.
- Buffers records in a parametrised FIFO with a valid/ready drain port, for trace capture and on-chip debug alongside the simulation-only mnemonic decoder.
- Never drives the CPU; purely observational.

Parameters:
DEPTH, 16, trace FIFO entries (power of two, >= 2).
AW, 24, monitored address width.
CYCW, 16, cycle-stamp counter width (wraps).
DROPW, 16, width of the saturating dropped-record counter.

Ports:
clk  in  1  clock
RST  in  1  synchronous active-high reset
en  in  1  trace enable; when low no new records start (a record in progress still completes)
sync  in  1  CPU is fetching an opcode/prefix byte this cycle
RDY  in  1  CPU bus cycle valid; all sampling qualified by RDY
AB  in  AW  CPU address bus
DI  in  8  CPU read data
out_valid  out  1  FIFO head record available
out_ready  in  1  consumer accepts head record
out_pc  out  AW  address of opcode byte (prefix excluded)
out_opcode  out  8  opcode byte
out_pfx  out  3  0 none, 1 A24, 2 R16, 3 R24, 4 A24+R16, 5 A24+R24, 7 unsupported prefix
out_operand  out  24  operand bytes, first fetched in [7:0]; unused bytes zero
out_nops  out  2  operand bytes captured (0-3)
out_trunc  out  1  next sync arrived before all operand bytes were seen
out_cycle  out  CYCW  cycle stamp at opcode fetch
dropped  out  DROPW  records lost to a full FIFO, saturating
level  out  log2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (synchronous, active-high RST): FSM to IDLE, FIFO empty, out_valid=0, all out_* = 0, dropped=0, level=0, cycle counter=0. Applies mid-record; the partial record is discarded.
- Cycle counter: increments every clk (not RDY-qualified), wraps at 2^CYCW.
- A fetch is a cycle with sync & RDY. Prefix byte = DI[3:0]==4'hF and DI != 8'h0F. Codes: 1F->1, 4F->2, 8F->3, 5F->4, 9F->5, any other xF->7. 0F is an ordinary opcode.
- FSM states:
  - IDLE: on fetch & en: if prefix, latch pfx and go PFX; else latch opcode, PC=AB, stamp, compute need, go OPS (or PUSH if need=0).
  - PFX: on next fetch: if prefix again, the newer prefix replaces the older; stay PFX. Else latch opcode as in IDLE.
  - OPS: each RDY & !sync cycle with AB == PC+1+nops (modulo 2^AW) stores DI into byte nops and increments nops. Cycles with any other address (stack, data, vector) are ignored. Reaching nops==need -> PUSH.
    - A fetch in OPS -> set trunc, push the partial record in that same cycle, then handle the fetch as in IDLE (back-to-back capture, no lost opcode).
  - PUSH: single-cycle write into FIFO -> IDLE.
    - A fetch coinciding with PUSH is handled as in IDLE in that same cycle.
- Operand length need(opcode, pfx), per table in package. aw = 3 if pfx in {1,4,5}, else 2. rw = 2 if pfx in {2,4}, 3 if pfx in {3,5}, else 1.
  - need = 0: implied, accumulator, stack, BRK, RTI, RTS, xF opcodes.
  - need = 1: branches/BRA, all zero-page and zp-indirect modes.
  - need = rw: immediate: A0, A2, C0, E0, 09/29/49/69/89/A9/C9/E9.
  - need = aw: absolute, abs,X, abs,Y, JSR, JMP abs, JMP (abs), JMP (abs,X).
- FIFO behaviour:
  - Push when full without a same-cycle pop: record dropped, dropped increments (saturates at all-ones).
  - Push and pop in the same cycle when full: both succeed.
  - Pop when out_valid & out_ready.
  - out_* are registered from the FIFO head; first-word latency = 1 cycle after push.
  - Pointers wrap modulo DEPTH.
- en deasserted while in PFX: the prefix is discarded, FSM -> IDLE.

Decomposition:
- Package cpu_trace_pkg holds:
  - pfx encoding constants.
  - Prefix-byte-to-code function.
  - Addressing-class enum (IMPL, REL, ZP, IMM, ABS).
  - Opcode-to-class function.
  - need() function of class, aw, rw.
- One sub-module: trace_fifo (parametrised DEPTH/width, synchronous, RST synchronous, level output). Decoder FSM stays in the top module.

Test Plan:
- Fetch A9 at 0x001000, then DI=0x42 at 0x001001 -> record pc=0x001000, opcode A9, pfx 0, operand 0x000042, nops 1, trunc 0.
- Fetch 9F at 0x002000, then AD at 0x002001, bytes 34,12,05 at 0x002002-4 -> pfx 5, pc 0x002001, operand 0x051234, nops 3.
- Fetch 4F, then A2, then DI 0x34, 0x12 -> pfx 2, operand 0x001234, nops 2. Repeat with 8F -> nops 3.
- Fetch 20 (JSR) at 0x000300, operand 00,80 with stack writes at 0x0001FF interleaved -> operand 0x008000, stack cycles ignored. Second fetch arriving after only 1 operand byte -> trunc=1, nops=1.
- out_ready=0, push DEPTH+3 records -> level=DEPTH, dropped=3. Then drain -> DEPTH records in order, out_valid falls after the last.
- Assert RST mid-OPS with level=5 -> next cycle level=0, out_valid=0, dropped=0; next fetch starts a clean record.
